// File: rtl/simotor_pkg.sv
// Shared types and helpers for the multi-channel motor/encoder simulator.
//   drive_e      : drive mode decoded from the synchronized {F,R} pair
//   enc_map      : position quadrant -> {B,A}
//   sat_signed   : symmetric saturation to a signed width
//   clog2_min1   : ceil(log2(n)) with a minimum of 1
package simotor_pkg;

  localparam int unsigned CALC_W = 64;

  // Encoding is literally {F,R} so decode is a plain cast.
  typedef enum logic [1:0] {
    DRV_COAST = 2'b00,
    DRV_REV   = 2'b01,
    DRV_FWD   = 2'b10,
    DRV_BRAKE = 2'b11
  } drive_e;

  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned w;
    w = 1;
    for (int unsigned v = 2; v < n; v = v * 32'd2) w = w + 1;
    return w;
  endfunction

  function automatic drive_e decode_drive(input logic f, input logic r);
    return drive_e'({f, r});
  endfunction

  // Gray sequence over the top two position bits: {B,A}.
  function automatic logic [1:0] enc_map(input logic [1:0] quad);
    logic [1:0] ba;
    case (quad)
      2'b00:   ba = 2'b01;
      2'b01:   ba = 2'b11;
      2'b10:   ba = 2'b10;
      default: ba = 2'b00;
    endcase
    return ba;
  endfunction

  // Clamp x to +/-(2^(w-1)-1).
  function automatic logic signed [CALC_W-1:0] sat_signed(input logic signed [CALC_W-1:0] x,
                                                          input int unsigned w);
    logic signed [CALC_W-1:0] lim;
    lim = $signed((CALC_W'(1) << (w - 1)) - CALC_W'(1));
    if (x > lim) return lim;
    if (x < -lim) return -lim;
    return x;
  endfunction

endpackage

// File: rtl/simotor_step.sv
// Combinational single-channel physics step.
//   speed_in/pos_in : current channel state
//   drive           : decoded drive mode
//   speed_out/pos_out : state after one update
module simotor_step
  import simotor_pkg::*;
#(
  parameter int unsigned POS_W       = 32,
  parameter int unsigned SPEED_W     = 32,
  parameter int unsigned POWER       = 512,
  parameter int unsigned FRICTION    = 60,
  parameter int unsigned SPEED_SHIFT = 16,
  parameter int unsigned BRAKE       = 256
) (
  input  logic [SPEED_W-1:0] speed_in,
  input  logic [POS_W-1:0]   pos_in,
  input  drive_e             drive,
  output logic [SPEED_W-1:0] speed_out,
  output logic [POS_W-1:0]   pos_out
);

  logic signed [CALC_W-1:0] applied;
  logic signed [CALC_W-1:0] fric;
  logic signed [CALC_W-1:0] s1;
  logic signed [CALC_W-1:0] mag;
  logic signed [CALC_W-1:0] red;
  logic signed [CALC_W-1:0] mag_new;
  logic signed [CALC_W-1:0] spd_new;

  // Wide signed arithmetic so no intermediate can overflow before saturation.
  always_comb begin
    applied = '0;
    fric    = $signed(CALC_W'(FRICTION));
    case (drive)
      DRV_FWD:   applied = $signed(CALC_W'(POWER));
      DRV_REV:   applied = -$signed(CALC_W'(POWER));
      DRV_BRAKE: fric    = $signed(CALC_W'(FRICTION + BRAKE));
      default:   ;
    endcase
    s1      = sat_signed(CALC_W'($signed(speed_in)) + applied, SPEED_W);
    mag     = (s1 < 0) ? -s1 : s1;
    red     = mag - (mag >>> SPEED_SHIFT) - fric;
    mag_new = ((mag > fric) && (red > 0)) ? red : '0;
    spd_new = (s1 > 0) ? mag_new : -mag_new;
    speed_out = SPEED_W'(spd_new);
    // Truncating the wide value is the same as sign-extended add mod 2^POS_W.
    pos_out   = pos_in + POS_W'(spd_new);
  end

endmodule

// File: rtl/simotor_mc.sv
// Multi-channel motor + quadrature encoder simulator, one shared physics
// step time-multiplexed round-robin over the channels.
//   CLOCK, RESET_N : clock, async active-low reset
//   ENABLE         : advances the slot counter and runs physics
//   F, R           : per-channel forward/reverse PWM (asynchronous)
//   CLEAR          : per-channel synchronous zeroing of speed/position
//   A, B, Z        : registered encoder outputs
//   SLOT           : channel updated at the next enabled edge
module simotor_mc
  import simotor_pkg::*;
#(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned POS_W       = 32,
  parameter int unsigned SPEED_W     = 32,
  parameter int unsigned POWER       = 512,
  parameter int unsigned FRICTION    = 60,
  parameter int unsigned SPEED_SHIFT = 16,
  parameter int unsigned BRAKE       = 256,
  parameter int unsigned IDX_DIV     = 0
) (
  input  logic                                CLOCK,
  input  logic                                RESET_N,
  input  logic                                ENABLE,
  input  logic [CHANNELS-1:0]                 F,
  input  logic [CHANNELS-1:0]                 R,
  input  logic [CHANNELS-1:0]                 CLEAR,
  output logic [CHANNELS-1:0]                 A,
  output logic [CHANNELS-1:0]                 B,
  output logic [CHANNELS-1:0]                 Z,
  output logic [clog2_min1(CHANNELS)-1:0]     SLOT
);

  localparam int unsigned SLOT_W = clog2_min1(CHANNELS);
  localparam int unsigned ZW     = IDX_DIV + 2;
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(CHANNELS - 1);

  logic [CHANNELS-1:0] f_meta, f_sync, r_meta, r_sync;
  logic [SPEED_W-1:0]  speed_q [CHANNELS];
  logic [POS_W-1:0]    pos_q   [CHANNELS];
  logic [SLOT_W-1:0]   slot_q;

  drive_e              drive_c;
  logic [SPEED_W-1:0]  speed_nxt;
  logic [POS_W-1:0]    pos_nxt;
  logic [1:0]          enc_nxt;
  logic                z_nxt;

  // Two-flop synchronizers on the PWM inputs.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      f_meta <= '0;
      f_sync <= '0;
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      f_meta <= F;
      f_sync <= f_meta;
      r_meta <= R;
      r_sync <= r_meta;
    end
  end

  assign drive_c = decode_drive(f_sync[slot_q], r_sync[slot_q]);

  simotor_step #(
    .POS_W       (POS_W),
    .SPEED_W     (SPEED_W),
    .POWER       (POWER),
    .FRICTION    (FRICTION),
    .SPEED_SHIFT (SPEED_SHIFT),
    .BRAKE       (BRAKE)
  ) u_step (
    .speed_in  (speed_q[slot_q]),
    .pos_in    (pos_q[slot_q]),
    .drive     (drive_c),
    .speed_out (speed_nxt),
    .pos_out   (pos_nxt)
  );

  assign enc_nxt = enc_map(pos_nxt[POS_W-1 -: 2]);
  assign z_nxt   = (pos_nxt[POS_W-1 -: ZW] == '0);

  // Slot counter, per-channel state and encoder outputs; CLEAR is applied
  // last so it overrides a coinciding update of the same channel.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      slot_q <= '0;
      for (int k = 0; k < CHANNELS; k++) begin
        speed_q[k] <= '0;
        pos_q[k]   <= '0;
      end
      A <= '1;
      B <= '0;
      Z <= '1;
    end else begin
      if (ENABLE) begin
        slot_q          <= (slot_q == SLOT_LAST) ? '0 : slot_q + SLOT_W'(1);
        speed_q[slot_q] <= speed_nxt;
        pos_q[slot_q]   <= pos_nxt;
        A[slot_q]       <= enc_nxt[0];
        B[slot_q]       <= enc_nxt[1];
        Z[slot_q]       <= z_nxt;
      end
      for (int k = 0; k < CHANNELS; k++) begin
        if (CLEAR[k]) begin
          speed_q[k] <= '0;
          pos_q[k]   <= '0;
          A[k]       <= 1'b1;
          B[k]       <= 1'b0;
          Z[k]       <= 1'b1;
        end
      end
    end
  end

  assign SLOT = slot_q;

endmodule

// File: tb/tb_simotor_mc.sv
// Self-checking bench for simotor_mc: reset/slot table, forward drive,
// reverse wrap, coast vs brake decay, randomized drive against a behavioural
// model, CLEAR on the channel's own slot, and ENABLE freeze. Two extra
// two-channel instances cover static friction and speed saturation.
module tb_simotor_mc;

  logic       clk = 1'b0;
  logic       rst_n, en, f_aux;
  logic [3:0] f, r, clr;
  logic [3:0] a, b, z;
  logic [1:0] slot;
  logic [1:0] a2, b2, z2, a3, b3, z3;
  logic       s2, s3;

  always #10 clk = ~clk;

  simotor_mc dut (
    .CLOCK(clk), .RESET_N(rst_n), .ENABLE(en), .F(f), .R(r), .CLEAR(clr),
    .A(a), .B(b), .Z(z), .SLOT(slot)
  );

  simotor_mc #(.CHANNELS(2), .POWER(60), .FRICTION(60)) dut2 (
    .CLOCK(clk), .RESET_N(rst_n), .ENABLE(en), .F({1'b0, f_aux}), .R(2'b00),
    .CLEAR(2'b00), .A(a2), .B(b2), .Z(z2), .SLOT(s2)
  );

  simotor_mc #(.CHANNELS(2), .SPEED_W(12), .POWER(2000), .SPEED_SHIFT(16)) dut3 (
    .CLOCK(clk), .RESET_N(rst_n), .ENABLE(en), .F({1'b0, f_aux}), .R(2'b00),
    .CLEAR(2'b00), .A(a3), .B(b3), .Z(z3), .SLOT(s3)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  longint     m_spd [4];
  longint     m_pos [4];
  logic [3:0] m_a, m_b, m_z;
  int         m_slot;
  logic [3:0] mf1, mf2, mr1, mr2;
  longint     x2_spd, x2_pos, x3_spd, x3_pos;
  logic       xf1, xf2;
  int         x_slot;
  int         x3_neg;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, $signed(act), $signed(exp));
    end
  endtask

  function automatic int drv_of(input logic fv, input logic rv);
    if (fv && !rv) return 1;
    if (!fv && rv) return 2;
    if (fv && rv) return 3;
    return 0;
  endfunction

  // One physics update from the rules, in plain integer arithmetic.
  function automatic longint phys(input longint spd, input int drv, input longint power,
                                  input longint friction, input longint brake,
                                  input int shift, input int sw);
    longint applied, fr, s1, lim, m, m2;
    applied = 0;
    fr = friction;
    if (drv == 1) applied = power;
    else if (drv == 2) applied = -power;
    else if (drv == 3) fr = friction + brake;
    lim = (longint'(1) << (sw - 1)) - 1;
    s1 = spd + applied;
    if (s1 > lim) s1 = lim;
    if (s1 < -lim) s1 = -lim;
    m = (s1 < 0) ? -s1 : s1;
    m2 = 0;
    if (m > fr) begin
      m2 = m - (m >>> shift) - fr;
      if (m2 < 0) m2 = 0;
    end
    return (s1 > 0) ? m2 : -m2;
  endfunction

  function automatic logic [1:0] m_enc(input longint pos);
    case (pos >> 30)
      0:       return 2'b01;
      1:       return 2'b11;
      2:       return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  function automatic longint dspd(input int k);
    return longint'($signed(dut.speed_q[k]));
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 4; k++) begin
      m_spd[k] = 0;
      m_pos[k] = 0;
    end
    m_a = 4'hF; m_b = 4'h0; m_z = 4'hF; m_slot = 0;
    mf1 = 0; mf2 = 0; mr1 = 0; mr2 = 0;
    x2_spd = 0; x2_pos = 0; x3_spd = 0; x3_pos = 0;
    xf1 = 0; xf2 = 0; x_slot = 0;
  endtask

  // Advance one clock, update the model with the inputs seen at that edge.
  task automatic step(input bit do_check);
    logic [3:0] cf, cr, cc;
    logic ce, cfa;
    int dv;
    cf = f; cr = r; cc = clr; ce = en; cfa = f_aux;
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      if (cc[k]) begin
        m_spd[k] = 0; m_pos[k] = 0; m_a[k] = 1'b1; m_b[k] = 1'b0; m_z[k] = 1'b1;
      end else if (ce && k == m_slot) begin
        dv = drv_of(mf2[k], mr2[k]);
        m_spd[k] = phys(m_spd[k], dv, 512, 60, 256, 16, 32);
        m_pos[k] = (m_pos[k] + m_spd[k]) & 64'hFFFF_FFFF;
        {m_b[k], m_a[k]} = m_enc(m_pos[k]);
        m_z[k] = ((m_pos[k] >> 30) == 0);
      end
    end
    if (ce) m_slot = (m_slot + 1) % 4;
    mf2 = mf1; mf1 = cf; mr2 = mr1; mr1 = cr;
    if (ce && x_slot == 0) begin
      dv = drv_of(xf2, 1'b0);
      x2_spd = phys(x2_spd, dv, 60, 60, 256, 16, 32);
      x2_pos = (x2_pos + x2_spd) & 64'hFFFF_FFFF;
      x3_spd = phys(x3_spd, dv, 2000, 60, 256, 16, 12);
      x3_pos = (x3_pos + x3_spd) & 64'hFFFF_FFFF;
    end
    if (ce) x_slot = 1 - x_slot;
    xf2 = xf1; xf1 = cfa;
    #1;
    if ($signed(dut3.speed_q[0]) < 0) x3_neg++;
    if (do_check) chk("outputs", {a, b, z, slot}, {m_a, m_b, m_z, 2'(m_slot)});
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_reset", {a, b, z, slot}, {4'hF, 4'h0, 4'hF, 2'd0});
    m_reset();
    f = 0; r = 0; clr = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic       en;
    logic [3:0] clr;
    logic [1:0] exp_slot;
    logic [3:0] exp_a, exp_b, exp_z;
  } vec_t;

  vec_t vt [11];

  initial begin
    #4_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    longint prev, n_coast, n_brake;
    logic [1:0] cur, last;
    logic [1:0] ba_seq[$];
    logic [1:0] exp_q [3];
    logic [13:0] snap;
    int cnt, viol;

    vt[0]  = '{1'b1, 4'h0, 2'd1, 4'hF, 4'h0, 4'hF};
    vt[1]  = '{1'b1, 4'h0, 2'd2, 4'hF, 4'h0, 4'hF};
    vt[2]  = '{1'b1, 4'h0, 2'd3, 4'hF, 4'h0, 4'hF};
    vt[3]  = '{1'b1, 4'h0, 2'd0, 4'hF, 4'h0, 4'hF};
    vt[4]  = '{1'b0, 4'h0, 2'd0, 4'hF, 4'h0, 4'hF};
    vt[5]  = '{1'b0, 4'h0, 2'd0, 4'hF, 4'h0, 4'hF};
    vt[6]  = '{1'b1, 4'h0, 2'd1, 4'hF, 4'h0, 4'hF};
    vt[7]  = '{1'b0, 4'hF, 2'd1, 4'hF, 4'h0, 4'hF};
    vt[8]  = '{1'b1, 4'h0, 2'd2, 4'hF, 4'h0, 4'hF};
    vt[9]  = '{1'b1, 4'h0, 2'd3, 4'hF, 4'h0, 4'hF};
    vt[10] = '{1'b1, 4'h0, 2'd0, 4'hF, 4'h0, 4'hF};
    exp_q = '{2'b11, 2'b10, 2'b00};

    rst_n = 1'b0; en = 1'b0; f = 0; r = 0; clr = 0; f_aux = 1'b0;
    x3_neg = 0;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {a, b, z, slot}, {4'hF, 4'h0, 4'hF, 2'd0});
    rst_n = 1'b1;

    // Reset state and slot sequencing, idle drive.
    for (int i = 0; i < 11; i++) begin
      en = vt[i].en;
      clr = vt[i].clr;
      step(1'b0);
      chk($sformatf("table_%0d", i), {a, b, z, slot},
          {vt[i].exp_a, vt[i].exp_b, vt[i].exp_z, vt[i].exp_slot});
    end
    clr = 0;

    // Forward drive on channel 0; aux instances driven in parallel.
    en = 1'b1; f = 4'b0001; f_aux = 1'b1;
    cnt = 0;
    while (dspd(0) == 0 && cnt < 20) begin
      step(1'b1);
      cnt++;
    end
    chk("fwd_latency", cnt, 5);
    chk("fwd_first_speed", dspd(0), 452);
    chk("fwd_first_pos", dut.pos_q[0], 452);
    repeat (4) step(1'b1);
    chk("fwd_second_speed", dspd(0), m_spd[0]);
    chk("fwd_second_pos", dut.pos_q[0], m_pos[0]);
    prev = dspd(0); viol = 0; last = 2'b01;
    for (int i = 0; i < 20000; i++) begin
      step(i % 64 == 0);
      if (dspd(0) < prev) viol++;
      prev = dspd(0);
      cur = {b[0], a[0]};
      if (cur !== last) begin
        ba_seq.push_back(cur);
        last = cur;
      end
    end
    chk("fwd_speed_monotonic", viol, 0);
    chk("fwd_quadrant_steps", ba_seq.size() >= 3, 1);
    for (int i = 0; i < 3; i++)
      chk($sformatf("fwd_quadrant_%0d", i), (i < ba_seq.size()) ? ba_seq[i] : 2'bxx, exp_q[i]);
    chk("fwd_end_speed", dspd(0), m_spd[0]);
    chk("fwd_end_pos", dut.pos_q[0], m_pos[0]);
    chk("fwd_other_idle", {a[3:1], b[3:1], z[3:1]}, {3'b111, 3'b000, 3'b111});

    // Static friction equals power: never moves.
    chk("static_speed", longint'($signed(dut2.speed_q[0])), 0);
    chk("static_pos", dut2.pos_q[0], 0);
    chk("static_outputs", {a2, b2, z2}, {2'b11, 2'b00, 2'b11});
    // Saturation: clamps at 2047 - friction, never negative.
    chk("sat_speed", longint'($signed(dut3.speed_q[0])), 1987);
    chk("sat_speed_model", longint'($signed(dut3.speed_q[0])), x3_spd);
    chk("sat_pos", dut3.pos_q[0], x3_pos);
    chk("sat_outputs", {a3, b3, z3},
        {1'b1, m_enc(x3_pos) & 2'b01 ? 1'b1 : 1'b0, 1'b0, m_enc(x3_pos) >> 1 ? 1'b1 : 1'b0,
         1'b1, (x3_pos >> 30) == 0});
    chk("sat_never_negative", x3_neg, 0);
    chk("aux_slots", {s2, s3}, {x_slot[0], x_slot[0]});
    f_aux = 1'b0;

    // Reverse from reset: wraps below zero, then coast.
    do_reset();
    en = 1'b1; r = 4'b0100;
    cnt = 0;
    while (dspd(2) == 0 && cnt < 20) begin
      step(1'b1);
      cnt++;
    end
    chk("rev_wrap_ba", {b[2], a[2]}, 2'b00);
    chk("rev_wrap_z", z[2], 1'b0);
    repeat (400) step(1'b1);
    r = 4'b0000;
    n_coast = 0;
    while (dspd(2) != 0 && n_coast < 20000) begin
      step(n_coast % 16 == 0);
      n_coast++;
    end
    chk("coast_settles", dspd(2), 0);

    // Same history, then brake.
    do_reset();
    en = 1'b1; r = 4'b0100;
    cnt = 0;
    while (dspd(2) == 0 && cnt < 20) begin
      step(1'b1);
      cnt++;
    end
    repeat (400) step(1'b1);
    f = 4'b0100; r = 4'b0100;
    n_brake = 0;
    while (dspd(2) != 0 && n_brake < 20000) begin
      step(n_brake % 16 == 0);
      n_brake++;
    end
    chk("brake_settles", dspd(2), 0);
    chk("brake_faster", n_brake < n_coast, 1);

    // Randomized drive, clears and enable against the model.
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      if (i % 32 == 0) begin
        f = 4'($urandom);
        r = 4'($urandom);
      end
      en = ($urandom_range(0, 7) != 0);
      clr = ($urandom_range(0, 63) == 0) ? 4'($urandom) : 4'h0;
      step(1'b1);
    end
    clr = 0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rand_speed_%0d", k), dspd(k), m_spd[k]);
      chk($sformatf("rand_pos_%0d", k), dut.pos_q[k], m_pos[k]);
    end

    // CLEAR on channel 1's own slot edge while moving.
    en = 1'b1; f = 4'b1111; r = 4'b0000;
    repeat (100) step(1'b1);
    cnt = 0;
    while (slot !== 2'd1 && cnt < 8) begin
      step(1'b1);
      cnt++;
    end
    chk("clr_slot_reached", slot, 2'd1);
    clr = 4'b0010;
    step(1'b1);
    clr = 4'b0000;
    chk("clr_speed", dspd(1), 0);
    chk("clr_pos", dut.pos_q[1], 0);
    chk("clr_baz", {b[1], a[1], z[1]}, 3'b011);
    chk("clr_other_speed", dspd(0), m_spd[0]);

    // ENABLE low freezes everything.
    en = 1'b0;
    snap = {m_a, m_b, m_z, 2'(m_slot)};
    for (int i = 0; i < 50; i++) begin
      step(1'b0);
      if (i % 10 == 9) chk("freeze", {a, b, z, slot}, snap);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
